rx_ingress_arbiter: RTL and testbench



---
 rtl/rx_ingress_arbiter_if.sv | 13 +
 rtl/rx_ingress_arbiter.sv | 130 +++++++++++++
 tb/tb_rx_ingress_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_ingress_arbiter_if.sv
// AXI-Stream bundle, LANES streams wide: the per-port ingress side or the single parser side.
interface rx_ingress_arbiter_if #(
    parameter int unsigned LANES  = 1,
    parameter int unsigned DATA_W = 64
);
    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tlast;
    logic [LANES-1:0]        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rx_ingress_arbiter.sv
// Packet-granular round-robin arbiter sharing one parser stream between NUM_PORTS ingress ports,
// with an idle watchdog that aborts and drains a stalled packet.
module rx_ingress_arbiter #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned PORT_W       = $clog2(NUM_PORTS),
    parameter int unsigned IDLE_TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rx_ingress_arbiter_if.slave     s_axis,
    rx_ingress_arbiter_if.master    m_axis,
    output logic [PORT_W-1:0]       m_axis_tid,
    output logic                    grant_valid,
    output logic                    pkt_abort,
    output logic [NUM_PORTS-1:0]    drop_active
);

    typedef enum logic [0:0] {StIdle, StPass} state_e;

    state_e                 state_q, state_d;
    logic [PORT_W-1:0]      grant_q, grant_d;
    logic [PORT_W-1:0]      last_grant_q, last_grant_d;
    logic [15:0]            cnt_q, cnt_d, cnt_inc;
    logic                   pkt_abort_q, pkt_abort_d;
    logic [NUM_PORTS-1:0]   drop_q, drop_d;

    logic [NUM_PORTS-1:0]   eligible;
    logic [PORT_W-1:0]      pick, idx;
    logic                   pick_found;
    logic [DATA_W-1:0]      src_data;
    logic                   src_valid, src_last, beat_ok, timeout;

    assign eligible  = s_axis.tvalid & ~drop_q;
    assign src_data  = s_axis.tdata[32'(grant_q) * DATA_W +: DATA_W];
    assign src_valid = s_axis.tvalid[grant_q];
    assign src_last  = s_axis.tlast[grant_q];
    assign beat_ok   = (state_q == StPass) && src_valid && m_axis.tready[0];
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign timeout   = (IDLE_TIMEOUT != 0) && (state_q == StPass) && !src_valid &&
                       (32'(cnt_inc) == IDLE_TIMEOUT);

    // Round-robin search starting just after the last port served.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = PORT_W'((32'(last_grant_q) + k) % NUM_PORTS);
            if (!pick_found && eligible[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tvalid = '0;
        m_axis.tlast  = '0;
        m_axis_tid    = '0;
        s_axis.tready = drop_q;
        if (state_q == StPass) begin
            m_axis.tdata           = src_data;
            m_axis.tvalid[0]       = src_valid;
            m_axis.tlast[0]        = src_last;
            m_axis_tid             = grant_q;
            s_axis.tready[grant_q] = m_axis.tready[0];
        end
    end

    assign grant_valid = (state_q == StPass);
    assign pkt_abort   = pkt_abort_q;
    assign drop_active = drop_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        pkt_abort_d  = 1'b0;
        // Dropping ports are always ready, so a presented tlast ends the drop.
        drop_d       = drop_q & ~(s_axis.tvalid & s_axis.tlast);
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = StPass;
                end
            end
            StPass: begin
                if (beat_ok) begin
                    cnt_d = '0;
                    if (src_last) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end
                end else if (timeout) begin
                    pkt_abort_d     = 1'b1;
                    drop_d[grant_q] = 1'b1;
                    last_grant_d    = grant_q;
                    state_d         = StIdle;
                end else if (!src_valid) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            cnt_q        <= '0;
            pkt_abort_q  <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            pkt_abort_q  <= pkt_abort_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_rx_ingress_arbiter.sv
// Randomised and directed bench for rx_ingress_arbiter against a packet-level reference model.
module tb_rx_ingress_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 64;
    localparam int PW  = 2;
    localparam int TO  = 8;
    localparam int CAP = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_ingress_arbiter_if #(.LANES(NP), .DATA_W(DW)) s_if ();
    rx_ingress_arbiter_if #(.LANES(1),  .DATA_W(DW)) m_if ();
    logic [PW-1:0] tid;
    logic          gv;
    logic          abort;
    logic [NP-1:0] drop;

    rx_ingress_arbiter #(
        .NUM_PORTS   (NP),
        .DATA_W      (DW),
        .PORT_W      (PW),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .m_axis_tid (tid),
        .grant_valid(gv),
        .pkt_abort  (abort),
        .drop_active(drop)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          gap;
    } beat_t;

    int total = 0;
    int bad   = 0;

    // Source-side packet queues (gap = idle cycles before the beat is presented)
    beat_t mem [NP][CAP];
    int    head [NP];
    int    tail [NP];
    int    wait_cnt [NP];
    int    delivered [NP];

    // Reference model state
    bit            busy_m;
    logic [PW-1:0] g_m;
    logic [PW-1:0] last_m;
    int            idle_m;
    logic [NP-1:0] drop_m;
    bit            abort_m;

    int  glog_port[$];
    int  glog_cyc[$];
    int  abort_cyc;
    bit  gv_prev;
    int  cyc;
    bit  rdy_rand;
    int  stall_lo;
    int  stall_hi;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_beat(input int p, input logic [63:0] data, input bit last, input int gap);
        mem[p][tail[p]] = '{data: data, last: last, gap: gap};
        tail[p]++;
    endtask

    task automatic push_pkt(input int p, input int len, input logic [63:0] base);
        for (int b = 0; b < len; b++) push_beat(p, base + 64'(b), b == len - 1, 0);
    endtask

    task automatic model_reset();
        busy_m  = 1'b0;
        g_m     = '0;
        last_m  = PW'(NP - 1);
        idle_m  = 0;
        drop_m  = '0;
        abort_m = 1'b0;
        gv_prev = 1'b0;
    endtask

    function automatic bit all_idle();
        bit r = !busy_m && (drop_m == '0) && (s_if.tvalid == '0);
        for (int i = 0; i < NP; i++) if (head[i] != tail[i]) r = 1'b0;
        return r;
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < NP; i++) begin
            if (!s_if.tvalid[i] && head[i] != tail[i]) begin
                if (wait_cnt[i] < mem[i][head[i]].gap) begin
                    wait_cnt[i]++;
                end else begin
                    s_if.tvalid[i]          = 1'b1;
                    s_if.tlast[i]           = mem[i][head[i]].last;
                    s_if.tdata[i*DW +: DW]  = mem[i][head[i]].data;
                end
            end
        end
        m_if.tready[0] = rdy_rand ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc < stall_hi);
    endtask

    // One clock: drive, check at negedge against the model, advance model and sources.
    task automatic step();
        logic [NP-1:0] v, l, acc, elig, exp_rdy;
        logic          r;
        logic [PW-1:0] p;
        drive_srcs();
        @(negedge clk);
        v = s_if.tvalid;
        l = s_if.tlast;
        r = m_if.tready[0];
        exp_rdy = drop_m;
        if (busy_m && r) exp_rdy[g_m] = 1'b1;
        check("grant_valid", 64'(gv), 64'(busy_m));
        check("pkt_abort", 64'(abort), 64'(abort_m));
        check("drop_active", 64'(drop), 64'(drop_m));
        check("s_tready", 64'(s_if.tready), 64'(exp_rdy));
        check("m_tvalid", 64'(m_if.tvalid), busy_m ? 64'(v[g_m]) : 64'd0);
        if (busy_m) begin
            check("m_tid", 64'(tid), 64'(g_m));
            if (v[g_m]) begin
                check("m_tdata", m_if.tdata, s_if.tdata[int'(g_m)*DW +: DW]);
                check("m_tlast", 64'(m_if.tlast), 64'(l[g_m]));
            end
        end
        if (abort) abort_cyc = cyc;
        if (gv && !gv_prev) begin
            glog_port.push_back(int'(tid));
            glog_cyc.push_back(cyc);
        end
        gv_prev = gv;
        if (m_if.tvalid[0] && r) delivered[tid]++;
        acc = s_if.tvalid & s_if.tready;

        abort_m = 1'b0;
        elig    = v & ~drop_m;
        drop_m  = drop_m & ~(v & l);
        if (busy_m) begin
            if (v[g_m] && r) begin
                idle_m = 0;
                if (l[g_m]) begin
                    busy_m = 1'b0;
                    last_m = g_m;
                end
            end else if (!v[g_m]) begin
                if (idle_m + 1 == TO) begin
                    abort_m     = 1'b1;
                    drop_m[g_m] = 1'b1;
                    busy_m      = 1'b0;
                    last_m      = g_m;
                end else begin
                    idle_m++;
                end
            end
        end else begin
            for (int k = 1; k <= NP; k++) begin
                p = PW'((int'(last_m) + k) % NP);
                if (!busy_m && elig[p]) begin
                    busy_m = 1'b1;
                    g_m    = p;
                    idle_m = 0;
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NP; i++) begin
            if (acc[i]) begin
                head[i]++;
                wait_cnt[i]   = 0;
                s_if.tvalid[i] = 1'b0;
                s_if.tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (!all_idle() && c < budget) begin
            step();
            c++;
        end
        check("drain", 64'(all_idle()), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, l0, dsum, gen;
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        rdy_rand = 1'b0;
        stall_lo = 0;
        stall_hi = 0;
        cyc = 0;
        abort_cyc = -1;
        for (int i = 0; i < NP; i++) begin
            head[i] = 0; tail[i] = 0; wait_cnt[i] = 0; delivered[i] = 0;
        end
        model_reset();

        #1;
        check("rst_grant_valid", 64'(gv), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata", m_if.tdata, 64'd0);
        check("rst_m_tid", 64'(tid), 64'd0);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_abort_drop", 64'({abort, drop}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three simultaneous requesters, then ports 0 and 3.
        for (int p = 0; p < 3; p++) push_pkt(p, 2, 64'(p) << 8);
        n = glog_port.size();
        drain(100);
        for (int k = 0; k < 3; k++) check("rr_order", 64'(glog_port[n+k]), 64'(k));
        for (int k = 1; k < 3; k++) check("rr_gap", 64'(glog_cyc[n+k] - glog_cyc[n+k-1]), 64'd3);
        push_pkt(0, 2, 64'h500);
        push_pkt(3, 2, 64'h600);
        n = glog_port.size();
        drain(100);
        check("rr_after2_first", 64'(glog_port[n]), 64'd3);
        check("rr_after2_second", 64'(glog_port[n+1]), 64'd0);

        // Single 4-beat packet from port 0.
        l0 = cyc;
        dsum = delivered[0];
        push_pkt(0, 4, 64'h11);
        for (int b = 0; b < 4; b++) mem[0][tail[0]-4+b].data = 64'h11 * 64'(b + 1);
        n = glog_port.size();
        drain(100);
        check("single_grant_port", 64'(glog_port[n]), 64'd0);
        check("single_grant_cycle", 64'(glog_cyc[n]), 64'(l0 + 1));
        check("single_beats", 64'(delivered[0] - dsum), 64'd4);

        // Parser backpressure for three cycles mid-packet.
        l0 = cyc;
        dsum = delivered[1];
        stall_lo = l0 + 3;
        stall_hi = l0 + 6;
        push_pkt(1, 4, 64'h7700);
        abort_cyc = -1;
        drain(100);
        stall_lo = 0;
        stall_hi = 0;
        check("bp_beats", 64'(delivered[1] - dsum), 64'd4);
        check("bp_no_abort", 64'(abort_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Watchdog: port 1 stalls after 2 of 5 beats; port 2 waits behind it.
        l0 = cyc;
        dsum = delivered[1];
        for (int b = 0; b < 5; b++) push_beat(1, 64'h100 + 64'(b), b == 4, (b == 2) ? 12 : 0);
        step();
        step();
        push_pkt(2, 2, 64'h200);
        n = glog_port.size();
        drain(200);
        check("wd_abort_cycle", 64'(abort_cyc), 64'(l0 + 11));
        check("wd_next_grant", 64'(glog_port[n]), 64'd2);
        check("wd_port1_beats", 64'(delivered[1] - dsum), 64'd2);
        check("wd_drop_cleared", 64'(drop), 64'd0);

        // Back-to-back single-beat packets from port 3.
        for (int k = 0; k < 4; k++) push_pkt(3, 1, 64'h3300 + 64'(k));
        n = glog_port.size();
        drain(100);
        for (int k = 1; k < 4; k++) begin
            check("b2b_port", 64'(glog_port[n+k]), 64'd3);
            check("b2b_spacing", 64'(glog_cyc[n+k] - glog_cyc[n+k-1]), 64'd2);
        end

        // Reset in the middle of a packet.
        push_pkt(0, 4, 64'hA0);
        step();
        step();
        drive_srcs();
        #2;
        check("prerst_m_tvalid", 64'(m_if.tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("midrst_m_tlast", 64'(m_if.tlast), 64'd0);
        check("midrst_m_tdata", m_if.tdata, 64'd0);
        check("midrst_grant_valid", 64'(gv), 64'd0);
        check("midrst_s_tready", 64'(s_if.tready), 64'd0);
        for (int i = 0; i < NP; i++) begin
            head[i] = tail[i];
            wait_cnt[i] = 0;
        end
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        l0 = cyc;
        push_pkt(0, 2, 64'hB0);
        n = glog_port.size();
        drain(100);
        check("postrst_grant_port", 64'(glog_port[n]), 64'd0);
        check("postrst_grant_cycle", 64'(glog_cyc[n]), 64'(l0 + 1));

        // Random traffic with random parser readiness.
        rdy_rand = 1'b1;
        dsum = 0;
        for (int i = 0; i < NP; i++) dsum += delivered[i];
        gen = 0;
        for (int k = 0; k < 40; k++) begin
            int p, len;
            p   = $urandom_range(0, NP - 1);
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++)
                push_beat(p, {$urandom, $urandom}, b == len - 1, $urandom_range(0, 2));
            gen += len;
        end
        drain(4000);
        rdy_rand = 1'b0;
        for (int i = 0; i < NP; i++) dsum -= delivered[i];
        check("rand_beats", 64'(-dsum), 64'(gen));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
